// File: rtl/trap_pkg.sv
// Shared types and helpers for the trapezoidal-filter delay-line sequencer.
package trap_pkg;

  // Width of a single delay value and of a delay sum / fill count.
  localparam int DELAY_W = 14;
  localparam int CNT_W   = DELAY_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } trap_state_e;

  // A delay pair is usable when both taps are non-zero and their sum fits the
  // ring buffer (depth - 1). The sum is formed one bit wider so it never wraps.
  function automatic logic delay_cfg_legal(
    input logic [DELAY_W-1:0] k,
    input logic [DELAY_W-1:0] l,
    input logic [CNT_W-1:0]   depth
  );
    logic [CNT_W-1:0] sum_s;
    sum_s = {1'b0, k} + {1'b0, l};
    return (k != 14'd0) && (l != 14'd0) && (sum_s <= (depth - 15'd1));
  endfunction

endpackage

// File: rtl/trap_valid_pipe.sv
// Fixed-depth valid shift register that tracks ring-buffer read latency.
// A synchronous flush discards every in-flight valid at once.
module trap_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic aresetn,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_r;

  // Advance valids one stage per clock; flush empties the whole pipe.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stage_r <= {DEPTH{1'b0}};
    end else if (flush) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/trap_delay_ctrl.sv
// Sequencer for the k-delay and l-delay ring buffers of the trapezoidal filter.
// Validates delay requests, gates ring-buffer enables from the sample stream and
// keeps the output valid low until both delay lines hold enough history.
// Optional macro TRAP_DELAY_CTRL_STATS_EN adds rej_cnt / refill_cnt counters.
module trap_delay_ctrl
  import trap_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int BUFFER_LENGTH    = 256,
  parameter int RD_LATENCY       = 2
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [DELAY_W-1:0]          cfg_kdelay,
  input  logic [DELAY_W-1:0]          cfg_ldelay,
  input  logic                        cfg_valid,
  output logic                        cfg_ack,
  output logic                        cfg_err,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] rb_wr_data,
  output logic                        rb_enwr,
  output logic                        rb_enrd,
  output logic [DELAY_W-1:0]          rb_kdelay,
  output logic [DELAY_W-1:0]          rb_ldelay,
  output logic                        m_axis_tvalid,
  output logic                        busy
`ifdef TRAP_DELAY_CTRL_STATS_EN
  ,
  output logic [15:0]                 rej_cnt,
  output logic [15:0]                 refill_cnt
`endif
);

  localparam logic [CNT_W-1:0] BUF_LEN_C = CNT_W'(BUFFER_LENGTH);
  localparam logic [CNT_W-1:0] RD_LAT_C  = CNT_W'(RD_LATENCY);

  trap_state_e                 state_r;
  logic [CNT_W-1:0]            fill_cnt_r;
  logic [DELAY_W-1:0]          kdelay_r;
  logic [DELAY_W-1:0]          ldelay_r;
  logic                        tready_r;
  logic                        busy_r;
  logic                        cfg_ack_r;
  logic                        cfg_err_r;
  logic [AXIS_TDATA_WIDTH-1:0] wr_data_r;
  logic                        enwr_r;
  logic                        enrd_r;
  logic                        run_rd_r;

  logic                        accept_s;
  logic                        legal_s;
  logic                        apply_s;
  logic                        reject_s;
  logic [CNT_W-1:0]            target_s;
  logic [CNT_W-1:0]            fill_next_s;

  // Handshake and configuration decode for the current cycle.
  always_comb begin
    accept_s = s_axis_tvalid && tready_r;
    legal_s  = delay_cfg_legal(cfg_kdelay, cfg_ldelay, BUF_LEN_C);
    apply_s  = cfg_valid && legal_s;
    reject_s = cfg_valid && !legal_s;
    // Priming needs k + l samples of history plus the read latency.
    target_s = {1'b0, kdelay_r} + {1'b0, ldelay_r} + RD_LAT_C;
    if (fill_cnt_r == target_s) begin
      fill_next_s = fill_cnt_r;
    end else begin
      fill_next_s = fill_cnt_r + 15'd1;
    end
  end

  // Control FSM with registered outputs; a legal config always re-primes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      fill_cnt_r <= 15'd0;
      kdelay_r   <= 14'd0;
      ldelay_r   <= 14'd0;
      tready_r   <= 1'b0;
      busy_r     <= 1'b0;
      cfg_ack_r  <= 1'b0;
      cfg_err_r  <= 1'b0;
      wr_data_r  <= {AXIS_TDATA_WIDTH{1'b0}};
      enwr_r     <= 1'b0;
      enrd_r     <= 1'b0;
      run_rd_r   <= 1'b0;
    end else begin
      cfg_ack_r <= apply_s;
      enwr_r    <= accept_s;
      enrd_r    <= accept_s;
      // A sample accepted alongside a config belongs to the new fill, not RUN.
      run_rd_r  <= accept_s && (state_r == RUN) && !apply_s;
      if (accept_s) begin
        wr_data_r <= s_axis_tdata;
      end
      if (apply_s) begin
        kdelay_r   <= cfg_kdelay;
        ldelay_r   <= cfg_ldelay;
        cfg_err_r  <= 1'b0;
        state_r    <= FILL;
        tready_r   <= 1'b1;
        busy_r     <= 1'b1;
        fill_cnt_r <= accept_s ? 15'd1 : 15'd0;
      end else begin
        if (reject_s) begin
          cfg_err_r <= 1'b1;
        end
        case (state_r)
          IDLE: begin
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
          end
          FILL: begin
            if (accept_s) begin
              fill_cnt_r <= fill_next_s;
              if (fill_next_s == target_s) begin
                state_r <= RUN;
                busy_r  <= 1'b0;
              end
            end
          end
          RUN: begin
            tready_r <= 1'b1;
            busy_r   <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  trap_valid_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_valid_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .flush   (apply_s),
    .din     (run_rd_r),
    .dout    (m_axis_tvalid)
  );

  assign cfg_ack       = cfg_ack_r;
  assign cfg_err       = cfg_err_r;
  assign s_axis_tready = tready_r;
  assign rb_wr_data    = wr_data_r;
  assign rb_enwr       = enwr_r;
  assign rb_enrd       = enrd_r;
  assign rb_kdelay     = kdelay_r;
  assign rb_ldelay     = ldelay_r;
  assign busy          = busy_r;

`ifdef TRAP_DELAY_CTRL_STATS_EN
  logic [15:0] rej_cnt_r;
  logic [15:0] refill_cnt_r;

  // Saturating counts of rejected requests and of FILL entries.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rej_cnt_r    <= 16'd0;
      refill_cnt_r <= 16'd0;
    end else begin
      if (reject_s && (rej_cnt_r != 16'hFFFF)) begin
        rej_cnt_r <= rej_cnt_r + 16'd1;
      end
      if (apply_s && (refill_cnt_r != 16'hFFFF)) begin
        refill_cnt_r <= refill_cnt_r + 16'd1;
      end
    end
  end

  assign rej_cnt    = rej_cnt_r;
  assign refill_cnt = refill_cnt_r;
`endif

endmodule

// File: tb/tb_trap_delay_ctrl.sv
// Directed self-checking bench for trap_delay_ctrl with a reference model and
// a scoreboard queue of expected m_axis_tvalid arrival cycles.
module tb_trap_delay_ctrl;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [13:0] cfg_kdelay = 14'd0;
  logic [13:0] cfg_ldelay = 14'd0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ack;
  logic        cfg_err;
  logic [15:0] s_axis_tdata = 16'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] rb_wr_data;
  logic        rb_enwr;
  logic        rb_enrd;
  logic [13:0] rb_kdelay;
  logic [13:0] rb_ldelay;
  logic        m_axis_tvalid;
  logic        busy;
`ifdef TRAP_DELAY_CTRL_STATS_EN
  logic [15:0] rej_cnt;
  logic [15:0] refill_cnt;
`endif

  trap_delay_ctrl #(
    .AXIS_TDATA_WIDTH (16),
    .BUFFER_LENGTH    (256),
    .RD_LATENCY       (2)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .cfg_kdelay    (cfg_kdelay),
    .cfg_ldelay    (cfg_ldelay),
    .cfg_valid     (cfg_valid),
    .cfg_ack       (cfg_ack),
    .cfg_err       (cfg_err),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rb_wr_data    (rb_wr_data),
    .rb_enwr       (rb_enwr),
    .rb_enrd       (rb_enrd),
    .rb_kdelay     (rb_kdelay),
    .rb_ldelay     (rb_ldelay),
    .m_axis_tvalid (m_axis_tvalid),
    .busy          (busy)
`ifdef TRAP_DELAY_CTRL_STATS_EN
    ,
    .rej_cnt       (rej_cnt),
    .refill_cnt    (refill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // Reference model state (0 = IDLE, 1 = FILL, 2 = RUN)
  int m_state, m_fill, m_k, m_l, m_err, m_ack, m_enwr, m_rej, m_refill;
  logic [15:0] m_wdata;
  int q[$];
  int cycle = 0;
  int busy_acc = 0;
  int last_acc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int k, input int l);
    return (k >= 1) && (l >= 1) && ((k + l) <= 255);
  endfunction

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_k = 0; m_l = 0; m_err = 0; m_ack = 0;
    m_enwr = 0; m_rej = 0; m_refill = 0; m_wdata = 16'd0;
    q.delete();
  endtask

  // One clock: update the model from the inputs being presented, then check.
  task automatic tick();
    bit acc, app, rej, exp_mv;
    acc = s_axis_tvalid && (m_state != 0);
    app = cfg_valid && legal(int'(cfg_kdelay), int'(cfg_ldelay));
    rej = cfg_valid && !legal(int'(cfg_kdelay), int'(cfg_ldelay));
    if (acc && busy) busy_acc++;
    m_ack = app ? 1 : 0;
    m_enwr = acc ? 1 : 0;
    if (acc) m_wdata = s_axis_tdata;
    if (rej && m_rej < 65535) m_rej++;
    if (app) begin
      if (m_refill < 65535) m_refill++;
      m_k = int'(cfg_kdelay);
      m_l = int'(cfg_ldelay);
      m_state = 1;
      m_fill = acc ? 1 : 0;
      m_err = 0;
      q.delete();
    end else begin
      if (rej) m_err = 1;
      if (acc && m_state == 1) begin
        m_fill++;
        if (m_fill == m_k + m_l + 2) m_state = 2;
      end else if (acc && m_state == 2) begin
        q.push_back(cycle + 3);
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (acc) last_acc = cycle;
    exp_mv = 1'b0;
    while (q.size() > 0 && q[0] < cycle) void'(q.pop_front());
    if (q.size() > 0 && q[0] == cycle) begin
      exp_mv = 1'b1;
      void'(q.pop_front());
    end
    chk("m_axis_tvalid", 32'(m_axis_tvalid), 32'(exp_mv));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("s_axis_tready", 32'(s_axis_tready), 32'(m_state != 0));
    chk("cfg_ack", 32'(cfg_ack), m_ack);
    chk("cfg_err", 32'(cfg_err), m_err);
    chk("rb_kdelay", 32'(rb_kdelay), m_k);
    chk("rb_ldelay", 32'(rb_ldelay), m_l);
    chk("rb_enwr", 32'(rb_enwr), m_enwr);
    chk("rb_enrd", 32'(rb_enrd), m_enwr);
    if (m_enwr != 0) chk("rb_wr_data", 32'(rb_wr_data), 32'(m_wdata));
`ifdef TRAP_DELAY_CTRL_STATS_EN
    chk("rej_cnt", 32'(rej_cnt), m_rej);
    chk("refill_cnt", 32'(refill_cnt), m_refill);
`endif
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 16'($urandom);
      tick();
      if (gap != 0) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic apply_cfg(input int k, input int l);
    cfg_kdelay = 14'(k);
    cfg_ldelay = 14'(l);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cfg_ack"}, 32'(cfg_ack), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_wr_data"}, 32'(rb_wr_data), 32'd0);
    chk({tag, "_enwr"}, 32'(rb_enwr), 32'd0);
    chk({tag, "_enrd"}, 32'(rb_enrd), 32'd0);
    chk({tag, "_kdelay"}, 32'(rb_kdelay), 32'd0);
    chk({tag, "_ldelay"}, 32'(rb_ldelay), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Reset applied between clock edges, released before the next rising edge.
  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    cfg_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst");
    #3;
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    int rise, a33;
    model_reset();
    #12;
    check_all_zero("por");
    aresetn = 1'b1;
    tick();
    tick();

    // 1: k=10, l=20 -> 32 samples of FILL, first valid 2 cycles after the 33rd
    apply_cfg(10, 20);
    chk("t1_ack", 32'(cfg_ack), 32'd1);
    busy_acc = 0;
    feed(32, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'hA5A5;
    tick();
    a33 = last_acc;
    s_axis_tvalid = 1'b0;
    rise = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_axis_tvalid && rise < 0) rise = cycle;
    end
    chk("t1_busy_samples", busy_acc, 32'd32);
    chk("t1_first_valid_lat", rise - a33, 32'd2);

    // 2: sum 256 rejected in IDLE, sum 255 accepted
    do_reset();
    apply_cfg(200, 56);
    chk("t2_err_set", 32'(cfg_err), 32'd1);
    chk("t2_no_ack", 32'(cfg_ack), 32'd0);
    chk("t2_stay_idle", 32'(s_axis_tready), 32'd0);
    apply_cfg(200, 55);
    chk("t2_ack", 32'(cfg_ack), 32'd1);
    chk("t2_err_clr", 32'(cfg_err), 32'd0);
    chk("t2_kdelay", 32'(rb_kdelay), 32'd200);

    // 3: reconfigure from RUN flushes the valid pipe and re-primes
    do_reset();
    apply_cfg(4, 4);
    feed(10, 0);
    feed(6, 0);
    apply_cfg(8, 8);
    chk("t3_flushed", 32'(m_axis_tvalid), 32'd0);
    chk("t3_kdelay", 32'(rb_kdelay), 32'd8);
    tick();
    chk("t3_flushed2", 32'(m_axis_tvalid), 32'd0);
    busy_acc = 0;
    feed(22, 0);
    chk("t3_fill_samples", busy_acc, 32'd18);

    // 4: 50% duty sample gaps during FILL do not change the RUN entry point
    apply_cfg(8, 8);
    busy_acc = 0;
    feed(22, 1);
    chk("t4_fill_samples_gaps", busy_acc, 32'd18);

    // 5: config and sample accepted in the same cycle
    cfg_kdelay = 14'd5;
    cfg_ldelay = 14'd6;
    cfg_valid = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h1234;
    tick();
    cfg_valid = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("t5_kdelay", 32'(rb_kdelay), 32'd5);
    chk("t5_ldelay", 32'(rb_ldelay), 32'd6);
    chk("t5_enwr", 32'(rb_enwr), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    busy_acc = 0;
    feed(16, 0);
    chk("t5_remaining_fill", busy_acc, 32'd12);

    // 6: asynchronous reset mid-RUN, then rejected requests
    s_axis_tvalid = 1'b1;
    tick();
    tick();
    do_reset();
    apply_cfg(0, 5);
    apply_cfg(5, 0);
    apply_cfg(16383, 16383);
    chk("t6_err", 32'(cfg_err), 32'd1);
`ifdef TRAP_DELAY_CTRL_STATS_EN
    chk("t6_rej_cnt", 32'(rej_cnt), 32'd3);
    chk("t6_refill_cnt", 32'(refill_cnt), 32'd0);
`endif
    apply_cfg(1, 1);
    feed(6, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
